// File: rtl/timing_counter_if.sv
// Control/status bundle for timing_counter: start/stop/config in, count and flags out.
interface timing_counter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_CMP = 2
);
  logic                   i_start;
  logic                   i_stop;
  logic                   i_mode;
  logic [WIDTH-1:0]       i_period;
  logic [N_CMP*WIDTH-1:0] i_cmp;
  logic [WIDTH-1:0]       o_counter;
  logic                   o_busy;
  logic                   o_tc;
  logic                   o_done;
  logic [N_CMP-1:0]       o_cmp;

  modport master (
    output i_start, i_stop, i_mode, i_period, i_cmp,
    input  o_counter, o_busy, o_tc, o_done, o_cmp
  );

  modport slave (
    input  i_start, i_stop, i_mode, i_period, i_cmp,
    output o_counter, o_busy, o_tc, o_done, o_cmp
  );
endinterface

// File: rtl/timing_counter.sv
// Period counter with free-run/one-shot modes, terminal-count/done flags and
// per-channel compare levels (e.g. pulse-width shaping).
module timing_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_CMP = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  timing_counter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int unsigned CMP_W  = N_CMP * WIDTH;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic [CMP_W-1:0] cmp_q, cmp_d;
  logic             done_q, done_d;
  logic             busy;
  logic             at_period;

  assign busy      = (state_q == ST_RUN);
  assign at_period = (cnt_q == period_q);

  // State and latched configuration; i_rst_n is active-high despite its name.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      cmp_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      cmp_q    <= cmp_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; stop always beats start and terminal count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    mode_d   = mode_q;
    cmp_d    = cmp_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.i_start && !bus.i_stop) begin
          state_d  = ST_RUN;
          period_d = bus.i_period;
          mode_d   = bus.i_mode;
          cmp_d    = bus.i_cmp;
        end
      end
      ST_RUN: begin
        if (bus.i_stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (at_period) begin
          cnt_d = '0;
          if (mode_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = WIDTH'(cnt_q + 1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.o_counter = cnt_q;
  assign bus.o_busy    = busy;
  assign bus.o_tc      = busy && at_period;
  assign bus.o_done    = done_q;

  // Compare level stays high while the count is below the channel threshold.
  for (genvar k = 0; k < int'(N_CMP); k++) begin : g_cmp
    assign bus.o_cmp[k] = busy && (cnt_q < cmp_q[k*WIDTH +: WIDTH]);
  end

endmodule
